// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the async instruction-memory read port from the pc
// and registers each fetched word into an IF/ID slot handed to decode over valid/ready.
//
// state | meaning
// PAUSE | en low; no fetches, all state held
// RUN   | fetching whenever the IF/ID slot is free
// ERR   | misaligned redirect seen; terminal until rst
module instr_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_plus4,
    output logic [31:0]       fetch_count,
    output logic              misaligned_err
);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_fetch_count;
    logic        r_misaligned_err;

    logic        w_slot_free;
    logic        w_fire;
    logic        w_misaligned;
    logic [31:0] w_pc_plus4;

    assign w_slot_free  = !r_id_valid || id_ready;
    assign w_fire       = (r_state == ST_RUN) && en && w_slot_free && !redirect_valid;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_pc_plus4   = r_pc + 32'd4;

    // Memory aliases on the low word-address bits; upper pc bits are ignored here.
    assign imem_addr = r_pc[ADDR_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_PAUSE;
            r_pc             <= RESET_PC;
            r_id_valid       <= 1'b0;
            r_id_instr       <= 32'd0;
            r_id_pc          <= 32'd0;
            r_id_pc_plus4    <= 32'd0;
            r_fetch_count    <= 32'd0;
            r_misaligned_err <= 1'b0;
        end else if (r_state == ST_ERR) begin
            r_id_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over a stalled slot; pc keeps the bad target for debug.
            r_id_valid <= 1'b0;
            r_pc       <= redirect_pc;
            if (w_misaligned) begin
                r_state          <= ST_ERR;
                r_misaligned_err <= 1'b1;
            end else begin
                r_state <= en ? ST_RUN : ST_PAUSE;
            end
        end else begin
            r_state <= en ? ST_RUN : ST_PAUSE;
            if (w_fire) begin
                r_id_valid    <= 1'b1;
                r_id_instr    <= imem_data;
                r_id_pc       <= r_pc;
                r_id_pc_plus4 <= w_pc_plus4;
                r_pc          <= w_pc_plus4;
                if (r_fetch_count != 32'hFFFF_FFFF) begin
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
            end else if (r_id_valid && id_ready) begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign id_valid       = r_id_valid;
    assign id_instr       = r_id_instr;
    assign id_pc          = r_id_pc;
    assign id_pc_plus4    = r_id_pc_plus4;
    assign fetch_count    = r_fetch_count;
    assign misaligned_err = r_misaligned_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory, a scoreboard of expected
// (instr, pc) pairs checked at each accepted handshake, plus per-scenario inline checks.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc;
    logic [31:0]       id_pc_plus4;
    logic [31:0]       fetch_count;
    logic              misaligned_err;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_count    (fetch_count),
        .misaligned_err (misaligned_err)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake that will be taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            checks++;
            if (exp_instr_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr %08h pc %08h, required no accept", id_instr, id_pc);
            end else begin
                logic [31:0] ei;
                logic [31:0] ep;
                ei = exp_instr_q.pop_front();
                ep = exp_pc_q.pop_front();
                if (id_instr !== ei || id_pc !== ep || id_pc_plus4 !== ep + 32'd4) begin
                    errors++;
                    $display("FAIL sb_accept: got instr %08h pc %08h pc4 %08h, required instr %08h pc %08h pc4 %08h",
                             id_instr, id_pc, id_pc_plus4, ei, ep, ep + 32'd4);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_instr_q.push_back(mem[pc[ADDR_W+1:2]]);
        exp_pc_q.push_back(pc);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        step();
        step();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0 ||
            fetch_count !== 32'd0 || misaligned_err !== 1'b0 || imem_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: got v %b i %08h pc %08h pc4 %08h cnt %0d err %b addr %h, required all zero",
                     id_valid, id_instr, id_pc, id_pc_plus4, fetch_count, misaligned_err, imem_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sequential();
        push(32'h0); push(32'h4);
        en = 1'b1; id_ready = 1'b1;
        step();
        step();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h2008_0005 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL seq_word0: got v %b i %08h pc %08h pc4 %08h, required 1 20080005 0 4",
                     id_valid, id_instr, id_pc, id_pc_plus4);
        end
        step();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h2009_000A || id_pc !== 32'h4) begin
            errors++;
            $display("FAIL seq_word1: got v %b i %08h pc %08h, required 1 2009000a 4", id_valid, id_instr, id_pc);
        end
        en = 1'b0;
        step();
        checks++;
        if (id_valid !== 1'b0 || fetch_count !== 32'd2 || imem_addr !== 10'd2) begin
            errors++;
            $display("FAIL seq_drain: got v %b cnt %0d addr %h, required 0 2 002", id_valid, fetch_count, imem_addr);
        end
    endtask

    task automatic test_stall();
        push(32'h8);
        en = 1'b1; id_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (id_valid !== 1'b1 || id_instr !== mem[2] || id_pc !== 32'h8 || imem_addr !== 10'd3) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v %b i %08h pc %08h addr %h, required 1 %08h 8 003",
                         i, id_valid, id_instr, id_pc, imem_addr, mem[2]);
            end
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_instr !== mem[3] || id_pc !== 32'hC || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL stall_release: got v %b i %08h pc %08h cnt %0d, required 1 %08h c 4",
                     id_valid, id_instr, id_pc, fetch_count, mem[3]);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h14;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || imem_addr !== 10'd5 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL redirect_flush: got v %b addr %h cnt %0d, required 0 005 4", id_valid, imem_addr, fetch_count);
        end
        push(32'h14);
        id_ready = 1'b1;
        step();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h3AFE_BABE || id_pc !== 32'h14) begin
            errors++;
            $display("FAIL redirect_target: got v %b i %08h pc %08h, required 1 3afebabe 14", id_valid, id_instr, id_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h3C;
        step();
        redirect_valid = 1'b0;
        push(32'h3C);
        step();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'hFACE_FEED || id_pc !== 32'h3C || fetch_count !== 32'd6) begin
            errors++;
            $display("FAIL redirect_3c: got v %b i %08h pc %08h cnt %0d, required 1 facefeed 3c 6",
                     id_valid, id_instr, id_pc, fetch_count);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h16;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misaligned_err !== 1'b1 || id_valid !== 1'b0 || fetch_count !== 32'd6 || imem_addr !== 10'd5) begin
            errors++;
            $display("FAIL misalign_enter: got err %b v %b cnt %0d addr %h, required 1 0 6 005",
                     misaligned_err, id_valid, fetch_count, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            en = i[0];
            redirect_valid = (i == 2);
            redirect_pc = 32'h40;
            step();
            checks++;
            if (misaligned_err !== 1'b1 || id_valid !== 1'b0 || fetch_count !== 32'd6 || imem_addr !== 10'd5) begin
                errors++;
                $display("FAIL err_sticky[%0d]: got err %b v %b cnt %0d addr %h, required 1 0 6 005",
                         i, misaligned_err, id_valid, fetch_count, imem_addr);
            end
        end
        redirect_valid = 1'b0; en = 1'b0; id_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (misaligned_err !== 1'b0 || id_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== '0 ||
            id_pc !== 32'd0 || id_instr !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got err %b v %b cnt %0d addr %h pc %08h i %08h, required all zero",
                     misaligned_err, id_valid, fetch_count, imem_addr, id_pc, id_instr);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_pause();
        push(32'h0); push(32'h4);
        en = 1'b1; id_ready = 1'b1;
        step();
        step();
        en = 1'b0;
        step();
        checks++;
        if (id_valid !== 1'b0 || fetch_count !== 32'd1 || imem_addr !== 10'd1) begin
            errors++;
            $display("FAIL pause_drop: got v %b cnt %0d addr %h, required 0 1 001", id_valid, fetch_count, imem_addr);
        end
        step();
        checks++;
        if (id_valid !== 1'b0 || fetch_count !== 32'd1 || imem_addr !== 10'd1) begin
            errors++;
            $display("FAIL pause_hold: got v %b cnt %0d addr %h, required 0 1 001", id_valid, fetch_count, imem_addr);
        end
        en = 1'b1;
        step();
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h2009_000A || fetch_count !== 32'd2) begin
            errors++;
            $display("FAIL pause_resume: got v %b pc %08h i %08h cnt %0d, required 1 4 2009000a 2",
                     id_valid, id_pc, id_instr, fetch_count);
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL wrap_addr_top: got addr %h, required 3ff", imem_addr);
        end
        push(32'hFFC); push(32'h1000);
        step();
        checks++;
        if (imem_addr !== 10'h000 || id_pc !== 32'hFFC) begin
            errors++;
            $display("FAIL wrap_alias: got addr %h pc %08h, required 000 ffc", imem_addr, id_pc);
        end
        step();
        en = 1'b0;
        checks++;
        if (id_pc !== 32'h1000 || id_instr !== 32'h2008_0005 || id_pc_plus4 !== 32'h1004) begin
            errors++;
            $display("FAIL wrap_next: got pc %08h i %08h pc4 %08h, required 1000 20080005 1004",
                     id_pc, id_instr, id_pc_plus4);
        end
        step();
        en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        push(32'hFFFF_FFFC);
        step();
        en = 1'b0;
        checks++;
        if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || imem_addr !== 10'h000) begin
            errors++;
            $display("FAIL pc_wrap: got pc %08h pc4 %08h addr %h, required fffffffc 0 000", id_pc, id_pc_plus4, imem_addr);
        end
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA000_0000 | i;
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h2009_000A;
        mem[5]  = 32'h3AFE_BABE;
        mem[15] = 32'hFACE_FEED;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_pause();
        test_wrap();

        checks++;
        if (exp_instr_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected words, required 0", exp_instr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage on the read side of the instruction memory wrapper. It drives the memory's asynchronous read port (dpra/dpo) from an internal program counter and registers each fetched word into an IF/ID output register. It hands each word to decode over a valid/ready handshake, and supports stall, pause, branch/jump redirect with flush, and a sticky misalignment error.

Parameters:
ADDR_W, 10, word-address width of instruction memory (drives dpra width)
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  fetch enable; 0 pauses fetching without losing state
imem_addr  out  ADDR_W  word address to memory read port (dpra)
imem_data  in  32  memory read data (dpo), combinational from imem_addr
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  target byte address for redirect
id_ready  in  1  decode accepts id_instr this cycle
id_valid  out  1  id_instr/id_pc hold a valid instruction
id_instr  out  32  fetched instruction word
id_pc  out  32  byte address of id_instr
id_pc_plus4  out  32  id_pc + 4
fetch_count  out  32  number of accepted fetches since reset, saturating
misaligned_err  out  1  sticky: redirect_pc[1:0] != 0 was seen

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, fetch_count=0, misaligned_err=0, state=PAUSE.
- imem_addr = pc[ADDR_W+1:2], combinational from the pc register. Addresses alias modulo 2^(ADDR_W+2) bytes. The pc itself wraps 32'hFFFF_FFFC -> 0.
- States:
  - PAUSE: entered when en=0.
  - RUN: entered when en=1.
  - ERR: terminal until rst.
  - Transitions: PAUSE->RUN on en=1; RUN->PAUSE on en=0; any state->ERR on a misaligned redirect.
- Slot free: slot_free = !id_valid | id_ready.
- Fire condition: fire = (state==RUN) & en & slot_free & !redirect_valid.
- On fire:
  - id_instr<=imem_data, id_pc<=pc, id_pc_plus4<=pc+4.
  - id_valid<=1, pc<=pc+4.
  - fetch_count<=fetch_count+1, saturating at 32'hFFFF_FFFF.
- Latency: the word at pc appears on id_instr the cycle after the fire edge. Throughput is 1 instruction/cycle while id_ready=1.
- Stall: id_valid=1 & id_ready=0 -> id_instr, id_pc, id_pc_plus4, id_valid and pc all hold.
- Drain: id_valid=1 & id_ready=1 & no fire (pause or redirect) -> id_valid<=0.
- Redirect (highest priority after rst, any state except ERR):
  - id_valid<=0 (flush; a held instruction is discarded even if id_ready=0).
  - pc<=redirect_pc.
  - No fetch that cycle; fetching resumes at the target on the next cycle if RUN.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - misaligned_err<=1, state<=ERR, id_valid<=0, pc<=redirect_pc (for debug).
  - No further fires until rst.
- ERR: redirect_valid and en are ignored; outputs hold except id_valid=0.
- Simultaneous en falling and id_ready high: the current word is consumed, id_valid<=0, pc holds.
- rst asserted mid-stall or mid-redirect: immediate async return to reset values.

Test Plan:
- Memory word0=32'h2008_0005, word1=32'h2009_000A, en=1, id_ready=1 after reset -> id_instr 2008_0005 (id_pc 0, id_pc_plus4 4), then 2009_000A (id_pc 4) on consecutive cycles; fetch_count=2.
- Hold id_ready=0 for 3 cycles while id_valid=1 at id_pc 8 -> id_instr, id_pc and imem_addr unchanged; release -> next word id_pc 0xC the following cycle, no skip or duplicate.
- redirect_valid=1 with redirect_pc=32'h14 while stalled -> held word flushed (id_valid=0 next cycle); next id_instr=32'h3AFE_BABE (word 5), id_pc=0x14.
- redirect_pc=32'h3C then 32'h16 -> first yields 32'hFACE_FEED at id_pc 0x3C; second sets misaligned_err=1, id_valid stays 0, fetch_count frozen, en toggling has no effect; rst clears all.
- en=0 for 2 cycles mid-stream -> pc and fetch_count hold, id_valid drops after acceptance; en=1 resumes at next sequential pc.
- pc at 32'hFFC (ADDR_W=10) -> imem_addr 10'h3FF, next imem_addr 10'h000 (alias), id_pc=32'h1000.
